// File: rtl/control_and_fetch1_if.sv
// control_and_fetch1_if
// Bundles every data/strobe signal exchanged between the first-layer control
// and fetch block and its surroundings (input image banks, output banks,
// weight SRAMs, BN SRAM and the 8-lane ASM array).
//   master : the control_and_fetch1 block (drives addresses, strobes, dout)
//   slave  : the environment (drives din and the bank status flags)
// All SRAM strobes (*_en, *_rd, *_wr) are active-low.
interface control_and_fetch1_if #(
  parameter int img_width = 16
);
  // Environment -> block
  logic [img_width-1:0] din;
  logic                 pre_sram_full1;
  logic                 pre_sram_full2;
  logic                 next_sram_empty1;
  logic                 next_sram_empty2;
  // Block -> environment
  logic [img_width-1:0] dout;
  logic [9:0]           pre_addr;
  logic                 pre_sram_en1;
  logic                 pre_sram_en2;
  logic                 pre_rd1;
  logic                 pre_rd2;
  logic                 next_sram_en1;
  logic                 next_sram_en2;
  logic                 next_wr1;
  logic                 next_wr2;
  logic [13:0]          next_addr;
  logic [8:0]           weights_addr;
  logic [7:0]           weights_sram_en;
  logic [7:0]           weights_sram_rd;
  logic                 img_request1;
  logic                 img_request2;
  logic                 calculate_en;
  logic [7:0]           asm_send;
  logic                 next_sram_full1;
  logic                 next_sram_full2;
  logic [6:0]           bn_addr;
  logic                 bn_en;
  logic                 bn_rd;
  logic [7:0]           asm_choose;

  modport master (
    input  din, pre_sram_full1, pre_sram_full2, next_sram_empty1, next_sram_empty2,
    output dout, pre_addr, pre_sram_en1, pre_sram_en2, pre_rd1, pre_rd2,
           next_sram_en1, next_sram_en2, next_wr1, next_wr2, next_addr,
           weights_addr, weights_sram_en, weights_sram_rd,
           img_request1, img_request2, calculate_en, asm_send,
           next_sram_full1, next_sram_full2, bn_addr, bn_en, bn_rd, asm_choose
  );

  modport slave (
    output din, pre_sram_full1, pre_sram_full2, next_sram_empty1, next_sram_empty2,
    input  dout, pre_addr, pre_sram_en1, pre_sram_en2, pre_rd1, pre_rd2,
           next_sram_en1, next_sram_en2, next_wr1, next_wr2, next_addr,
           weights_addr, weights_sram_en, weights_sram_rd,
           img_request1, img_request2, calculate_en, asm_send,
           next_sram_full1, next_sram_full2, bn_addr, bn_en, bn_rd, asm_choose
  );
endinterface

// File: rtl/control_and_fetch1.sv
// control_and_fetch1
// First-layer control and fetch block. Picks the ping-pong bank pair selected
// by sel, and for each of 8 passes (one per ASM lane) reads one BN parameter,
// streams all 1024 input words to the ASM array while reading the matching
// weight SRAM, flushes the read pipe, then tells the lane to write its result
// to the output bank. At job end it pulses img_request/next_sram_full for the
// bank pair and flips sel.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : control_and_fetch1_if.master (all SRAM/ASM signals)
module control_and_fetch1 #(
  parameter int img_width = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  control_and_fetch1_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BN    = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [9:0] LAST_K = 10'd1023;
  localparam logic [2:0] LAST_P = 3'd7;

  function automatic logic [7:0] lane_onehot(input logic [2:0] lane);
    lane_onehot = 8'd1 << lane;
  endfunction

  state_t               state_q;
  logic                 sel_q;        // 0 = bank pair 1, 1 = bank pair 2
  logic [2:0]           pass_q;
  logic                 drain_q;
  logic [9:0]           pre_addr_q;   // doubles as the fetch index k
  logic                 pre_stb1_q;
  logic                 pre_stb2_q;
  logic [7:0]           wt_stb_q;
  logic                 bn_stb_q;
  logic [6:0]           bn_addr_q;
  logic                 next_stb1_q;
  logic                 next_stb2_q;
  logic [13:0]          next_addr_q;
  logic [7:0]           asm_send_q;
  logic                 done1_q;
  logic                 done2_q;
  logic                 rd_v1_q;      // a read was issued in the previous cycle
  logic                 calc_q;
  logic [7:0]           choose_q;
  logic [img_width-1:0] dout_q;
  logic                 start_s;

  // Start condition evaluated only for the bank pair currently selected.
  assign start_s = sel_q ? (bus.pre_sram_full2 & bus.next_sram_empty2)
                         : (bus.pre_sram_full1 & bus.next_sram_empty1);

  // Job sequencer: state, pass counter, bank pointer and all strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      pass_q      <= 3'd0;
      drain_q     <= 1'b0;
      pre_addr_q  <= 10'd0;
      pre_stb1_q  <= 1'b1;
      pre_stb2_q  <= 1'b1;
      wt_stb_q    <= 8'hFF;
      bn_stb_q    <= 1'b1;
      bn_addr_q   <= 7'd0;
      next_stb1_q <= 1'b1;
      next_stb2_q <= 1'b1;
      next_addr_q <= 14'd0;
      asm_send_q  <= 8'h00;
      done1_q     <= 1'b0;
      done2_q     <= 1'b0;
    end else begin
      // Strobes and pulses idle unless the coming state asserts them.
      pre_stb1_q  <= 1'b1;
      pre_stb2_q  <= 1'b1;
      wt_stb_q    <= 8'hFF;
      bn_stb_q    <= 1'b1;
      next_stb1_q <= 1'b1;
      next_stb2_q <= 1'b1;
      asm_send_q  <= 8'h00;
      done1_q     <= 1'b0;
      done2_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q   <= ST_BN;
            pass_q    <= 3'd0;
            bn_stb_q  <= 1'b0;
            bn_addr_q <= 7'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BN: begin
          state_q    <= ST_FETCH;
          pre_addr_q <= 10'd0;
          pre_stb1_q <= sel_q;
          pre_stb2_q <= ~sel_q;
          wt_stb_q   <= ~lane_onehot(pass_q);
        end
        ST_FETCH: begin
          if (pre_addr_q == LAST_K) begin
            state_q <= ST_DRAIN;
            drain_q <= 1'b0;
          end else begin
            pre_addr_q <= pre_addr_q + 10'd1;
            pre_stb1_q <= sel_q;
            pre_stb2_q <= ~sel_q;
            wt_stb_q   <= ~lane_onehot(pass_q);
          end
        end
        ST_DRAIN: begin
          // Two cycles so the last word reaches dout before the lane writes out.
          if (drain_q) begin
            state_q     <= ST_SEND;
            asm_send_q  <= lane_onehot(pass_q);
            next_stb1_q <= sel_q;
            next_stb2_q <= ~sel_q;
            next_addr_q <= {11'd0, pass_q};
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (pass_q == LAST_P) begin
            state_q <= ST_DONE;
            done1_q <= ~sel_q;
            done2_q <= sel_q;
          end else begin
            state_q   <= ST_BN;
            pass_q    <= pass_q + 3'd1;
            bn_stb_q  <= 1'b0;
            bn_addr_q <= {4'd0, pass_q + 3'd1};
          end
        end
        ST_DONE: begin
          sel_q   <= ~sel_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data pipe: strobe in t, din in t+1, dout/calculate_en in t+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q  <= 1'b0;
      calc_q   <= 1'b0;
      choose_q <= 8'h00;
      dout_q   <= '0;
    end else begin
      rd_v1_q  <= (state_q == ST_FETCH);
      calc_q   <= rd_v1_q;
      choose_q <= rd_v1_q ? lane_onehot(pass_q) : 8'h00;
      if (rd_v1_q) begin
        dout_q <= bus.din;
      end else begin
        dout_q <= dout_q;
      end
    end
  end

  assign bus.dout            = dout_q;
  assign bus.pre_addr        = pre_addr_q;
  assign bus.pre_sram_en1    = pre_stb1_q;
  assign bus.pre_rd1         = pre_stb1_q;
  assign bus.pre_sram_en2    = pre_stb2_q;
  assign bus.pre_rd2         = pre_stb2_q;
  assign bus.weights_addr    = pre_addr_q[8:0];   // wraps 511 -> 0 with k
  assign bus.weights_sram_en = wt_stb_q;
  assign bus.weights_sram_rd = wt_stb_q;
  assign bus.bn_addr         = bn_addr_q;
  assign bus.bn_en           = bn_stb_q;
  assign bus.bn_rd           = bn_stb_q;
  assign bus.next_sram_en1   = next_stb1_q;
  assign bus.next_wr1        = next_stb1_q;
  assign bus.next_sram_en2   = next_stb2_q;
  assign bus.next_wr2        = next_stb2_q;
  assign bus.next_addr       = next_addr_q;
  assign bus.asm_send        = asm_send_q;
  assign bus.img_request1    = done1_q;
  assign bus.next_sram_full1 = done1_q;
  assign bus.img_request2    = done2_q;
  assign bus.next_sram_full2 = done2_q;
  assign bus.calculate_en    = calc_q;
  assign bus.asm_choose      = choose_q;

endmodule

// File: tb/tb_control_and_fetch1.sv
// Scoreboard bench for control_and_fetch1: a timing/data model of whole jobs
// pushes expected events into queues; a negedge monitor pops and compares
// each time the DUT presents a BN read, image read, accumulate word, lane send
// or job-done pulse.
module tb_control_and_fetch1;

  localparam int PASS_CYC = 1028;
  localparam int JOB_CYC  = 8226;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_and_fetch1_if #(.img_width(16)) bus ();
  control_and_fetch1 #(.img_width(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic full1, full2, empty1, empty2;
  logic [15:0] din_r;
  logic [15:0] mem1 [1024];
  logic [15:0] mem2 [1024];
  assign bus.pre_sram_full1   = full1;
  assign bus.pre_sram_full2   = full2;
  assign bus.next_sram_empty1 = empty1;
  assign bus.next_sram_empty2 = empty2;
  assign bus.din              = din_r;

  int cyc = 0;
  bit mon_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int cyc; logic [6:0] addr; } bn_t;
  typedef struct { int cyc; bit bank; logic [9:0] addr; logic [2:0] lane; } rd_t;
  typedef struct { int cyc; logic [15:0] data; logic [7:0] choose; } calc_t;
  typedef struct { int cyc; bit bank; logic [2:0] lane; } send_t;
  typedef struct { int cyc; bit bank; } done_t;

  bn_t   bn_q[$];
  rd_t   rd_q[$];
  calc_t calc_q[$];
  send_t send_q[$];
  done_t done_q[$];

  // Input image banks: synchronous read, one-cycle latency, hold when idle.
  always @(posedge clk) begin
    if (!bus.pre_sram_en1 && !bus.pre_rd1) din_r <= mem1[bus.pre_addr];
    else if (!bus.pre_sram_en2 && !bus.pre_rd2) din_r <= mem2[bus.pre_addr];
  end

  // Cycle index since the last reset release (cycle 0 = first IDLE cycle).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int q_total();
    return bn_q.size() + rd_q.size() + calc_q.size() + send_q.size() + done_q.size();
  endfunction

  // Expected events of one full job on bank (0 = pair 1) starting in IDLE at cycle s.
  task automatic push_job(input bit bank, input int s);
    for (int p = 0; p < 8; p++) begin
      int base = s + 1 + PASS_CYC * p;
      bn_q.push_back('{cyc: base, addr: 7'(p)});
      for (int k = 0; k < 1024; k++) begin
        rd_q.push_back('{cyc: base + 1 + k, bank: bank, addr: 10'(k), lane: 3'(p)});
        calc_q.push_back('{cyc: base + 3 + k, data: bank ? mem2[k] : mem1[k],
                           choose: 8'(1 << p)});
      end
      send_q.push_back('{cyc: base + PASS_CYC - 1, bank: bank, lane: 3'(p)});
    end
    done_q.push_back('{cyc: s + JOB_CYC - 1, bank: bank});
  endtask

  task automatic check_reset_vals();
    check("rst_pre_strobes", 32'({bus.pre_sram_en1, bus.pre_rd1, bus.pre_sram_en2, bus.pre_rd2}), 32'hF);
    check("rst_next_strobes", 32'({bus.next_sram_en1, bus.next_wr1, bus.next_sram_en2, bus.next_wr2}), 32'hF);
    check("rst_wt_strobes", 32'({bus.weights_sram_en, bus.weights_sram_rd}), 32'hFFFF);
    check("rst_bn_strobes", 32'({bus.bn_en, bus.bn_rd}), 32'h3);
    check("rst_addrs", 32'({bus.pre_addr, bus.weights_addr, bus.bn_addr}), 32'h0);
    check("rst_next_addr", 32'(bus.next_addr), 32'h0);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_pulses", 32'({bus.calculate_en, bus.asm_send, bus.asm_choose, bus.img_request1,
                             bus.img_request2, bus.next_sram_full1, bus.next_sram_full2}), 32'h0);
  endtask

  // Monitor: compare every DUT-presented event with the head of its queue.
  always @(negedge clk) begin : monitor
    bn_t   b;
    rd_t   r;
    calc_t c;
    send_t sd;
    done_t d;
    logic [7:0] exp_w;
    if (mon_en) begin
      if (!bus.bn_en || !bus.bn_rd) begin
        if (bn_q.size() == 0) check("unexpected_bn", 32'({bus.bn_en, bus.bn_rd}), 32'h3);
        else begin
          b = bn_q.pop_front();
          check("bn_cycle", 32'(cyc), 32'(b.cyc));
          check("bn_strobes", 32'({bus.bn_en, bus.bn_rd}), 32'h0);
          check("bn_addr", 32'(bus.bn_addr), 32'(b.addr));
        end
      end
      if (!bus.pre_sram_en1 || !bus.pre_rd1 || !bus.pre_sram_en2 || !bus.pre_rd2) begin
        if (rd_q.size() == 0)
          check("unexpected_read", 32'({bus.pre_sram_en1, bus.pre_rd1, bus.pre_sram_en2, bus.pre_rd2}), 32'hF);
        else begin
          r = rd_q.pop_front();
          exp_w = ~(8'd1 << r.lane);
          check("rd_cycle", 32'(cyc), 32'(r.cyc));
          check("rd_strobes", 32'({bus.pre_sram_en1, bus.pre_rd1, bus.pre_sram_en2, bus.pre_rd2}),
                r.bank ? 32'hC : 32'h3);
          check("pre_addr", 32'(bus.pre_addr), 32'(r.addr));
          check("weights_addr", 32'(bus.weights_addr), 32'(r.addr[8:0]));
          check("weights_en", 32'(bus.weights_sram_en), 32'(exp_w));
          check("weights_rd", 32'(bus.weights_sram_rd), 32'(exp_w));
        end
      end else begin
        check("weights_idle", 32'({bus.weights_sram_en, bus.weights_sram_rd}), 32'hFFFF);
      end
      if (bus.calculate_en) begin
        if (calc_q.size() == 0) check("unexpected_calc", 32'(bus.calculate_en), 32'h0);
        else begin
          c = calc_q.pop_front();
          check("calc_cycle", 32'(cyc), 32'(c.cyc));
          check("dout", 32'(bus.dout), 32'(c.data));
          check("asm_choose", 32'(bus.asm_choose), 32'(c.choose));
        end
      end else begin
        check("choose_idle", 32'(bus.asm_choose), 32'h0);
      end
      if (bus.asm_send != 8'h00 || !bus.next_sram_en1 || !bus.next_wr1 || !bus.next_sram_en2 || !bus.next_wr2) begin
        if (send_q.size() == 0) check("unexpected_send", 32'(bus.asm_send), 32'h0);
        else begin
          sd = send_q.pop_front();
          exp_w = 8'd1 << sd.lane;
          check("send_cycle", 32'(cyc), 32'(sd.cyc));
          check("asm_send", 32'(bus.asm_send), 32'(exp_w));
          check("next_addr", 32'(bus.next_addr), 32'(sd.lane));
          check("next_strobes", 32'({bus.next_sram_en1, bus.next_wr1, bus.next_sram_en2, bus.next_wr2}),
                sd.bank ? 32'hC : 32'h3);
        end
      end
      if (bus.img_request1 || bus.img_request2 || bus.next_sram_full1 || bus.next_sram_full2) begin
        if (done_q.size() == 0)
          check("unexpected_done", 32'({bus.img_request1, bus.next_sram_full1, bus.img_request2, bus.next_sram_full2}), 32'h0);
        else begin
          d = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("done_pulses", 32'({bus.img_request1, bus.next_sram_full1, bus.img_request2, bus.next_sram_full2}),
                d.bank ? 32'h3 : 32'hC);
        end
      end
    end
  end

  // Stimulus: three back-to-back jobs, reset mid-job, one more job, idle checks.
  initial begin
    int target;
    int guard;
    full1 = 1'b1; full2 = 1'b1; empty1 = 1'b1; empty2 = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      mem1[k] = 16'(k);
      mem2[k] = 16'($urandom);
    end
    push_job(1'b0, 0);
    push_job(1'b1, JOB_CYC);
    push_job(1'b0, 2 * JOB_CYC);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_vals();

    // Reset lands on the cycle reading k=500 of the third pass of job 3.
    target = 2 * JOB_CYC + 1 + 2 * PASS_CYC + 1 + 500;
    guard = 0;
    while (cyc != target && guard < 30000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_reset_point", 32'(cyc), 32'(target));
    rst = 1'b1;
    @(posedge clk);
    bn_q.delete(); rd_q.delete(); calc_q.delete(); send_q.delete(); done_q.delete();
    @(negedge clk);
    check_reset_vals();

    for (int k = 0; k < 1024; k++) mem1[k] = 16'($urandom);
    push_job(1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // Flags dropped mid-job must not disturb the running job.
    repeat (5) @(posedge clk);
    #1;
    full1 = 1'b0; full2 = 1'b0;
    guard = 0;
    while (q_total() != 0 && guard < 9000) begin
      @(posedge clk);
      guard++;
    end
    check("job_drain", 32'(q_total()), 32'h0);

    // sel now points at pair 2: pair-1 flags alone, or pair 2 without space, start nothing.
    #1;
    full1 = 1'b1; empty1 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    full2 = 1'b1; empty2 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_pre_strobes", 32'({bus.pre_sram_en1, bus.pre_rd1, bus.pre_sram_en2, bus.pre_rd2}), 32'hF);
    check("idle_bn_strobes", 32'({bus.bn_en, bus.bn_rd}), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
